universal_register: RTL

Parametrised successor to the team's 8-bit enable/reset register: a WIDTH-bit register that holds, loads, clears, and performs multi-cycle shift/rotate operations by a programmable amount. Operations are started with a start strobe and complete with a busy/done handshake. The block sits in datapaths that need a loadable working register with serial shifting, for example serialisers, bit-field alignment and simple multiply/divide sequencing.

---
 rtl/universal_register_pkg.sv | 25 ++
 rtl/universal_register_step.sv | 45 ++++
 rtl/universal_register.sv | 100 ++++++++++
 3 files changed

// File: rtl/universal_register_pkg.sv
// Shared types for the universal working register: operation codes and FSM states.
package universal_register_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_CLR  = 3'd2,
        MODE_SHL  = 3'd3,
        MODE_SHR  = 3'd4,
        MODE_ROL  = 3'd5,
        MODE_ROR  = 3'd6,
        MODE_ASR  = 3'd7
    } mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Codes from SHL upwards are the multi-cycle shift/rotate family.
    function automatic logic is_shift(input mode_t m);
        return (m >= MODE_SHL);
    endfunction

endpackage

// File: rtl/universal_register_step.sv
// Single-bit shift/rotate step: next register value and the bit that leaves it.
module universal_register_step
    import universal_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q_next,
    output logic             bit_out
);

    always_comb begin
        q_next  = q;
        bit_out = 1'b0;
        case (mode)
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], ser_in};
                bit_out = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next  = {ser_in, q[WIDTH-1:1]};
                bit_out = q[0];
            end
            MODE_ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                bit_out = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                bit_out = q[0];
            end
            MODE_ASR: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                bit_out = q[0];
            end
            default: begin
                q_next  = q;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_register.sv
// Loadable WIDTH-bit working register with multi-cycle shift/rotate by a programmable amount.
//   state    | meaning
//   ST_IDLE  | waiting for start; single-cycle ops and the first shift step happen here
//   ST_SHIFT | applying the remaining shift steps, busy=1
module universal_register
    import universal_register_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_t           state;
    mode_t            mode_r;
    mode_t            mode_in;
    mode_t            step_mode;
    logic [AMT_W-1:0] remaining;
    logic [WIDTH-1:0] step_q;
    logic             step_bit;

    assign mode_in = mode_t'(mode);
    // The accept edge already performs the first step, so the live mode drives the stepper in IDLE.
    assign step_mode = (state == ST_SHIFT) ? mode_r : mode_in;
    assign busy      = (state == ST_SHIFT);

    universal_register_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q       (q),
        .mode    (step_mode),
        .ser_in  (ser_in),
        .q_next  (step_q),
        .bit_out (step_bit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            mode_r    <= MODE_HOLD;
            remaining <= '0;
            q         <= '0;
            ser_out   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (enable) begin
                if (state == ST_IDLE) begin
                    if (start) begin
                        mode_r <= mode_in;
                        case (mode_in)
                            MODE_HOLD: done <= 1'b1;
                            MODE_LOAD: begin
                                q    <= d;
                                done <= 1'b1;
                            end
                            MODE_CLR: begin
                                q    <= '0;
                                done <= 1'b1;
                            end
                            default: begin
                                if (amount == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    q         <= step_q;
                                    ser_out   <= step_bit;
                                    remaining <= amount - AMT_W'(1);
                                    if (amount == AMT_W'(1))
                                        done <= 1'b1;
                                    else
                                        state <= ST_SHIFT;
                                end
                            end
                        endcase
                    end
                end else begin
                    q         <= step_q;
                    ser_out   <= step_bit;
                    remaining <= remaining - AMT_W'(1);
                    if (remaining == AMT_W'(1)) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
